ahb_lite_arbiter: RTL
=====================

Name: ahb_lite_arbiter

Overview:
- Two-master, one-slave arbiter for the 8-bit AHB-Lite-style bus used by the Controller/Peripheral pair.
- Each master posts a single read or write transfer.
- The arbiter picks one master by round-robin, drives the shared bus signals (write, trans, waddr, wdata) to the Peripheral, and waits for readyout.
- It then returns rdata and a done pulse to the winning master, or an err pulse if the Peripheral stalls past a timeout.

Parameters:
WIDTH, 8, address and data width on both master and bus side
TIMEOUT, 15, max cycles trans may stay high without readyout before abort (1..2^TWIDTH-1)
TWIDTH, 4, width of the timeout counter

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  master 0 requests a transfer; held with its fields until done0/err0
write0  input  1  master 0 direction: 1=write, 0=read
addr0  input  WIDTH  master 0 address
wdata0  input  WIDTH  master 0 write data
grant0  output  1  master 0 owns the bus (BUSY or RESP for master 0)
done0  output  1  one-cycle pulse: master 0 transfer completed
err0  output  1  one-cycle pulse: master 0 transfer timed out
rdata0  output  WIDTH  read data for master 0; updated only on a read that completes
req1, write1, addr1, wdata1, grant1, done1, err1, rdata1: same as master 0, for master 1
write  output  1  bus direction to the Peripheral
trans  output  1  bus transfer active
waddr  output  WIDTH  bus address
wdata  output  WIDTH  bus write data
readyout  input  1  Peripheral completes the current transfer this cycle
rdata  input  WIDTH  Peripheral read data; valid when readyout=1

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately) clears:
  - all outputs to 0;
  - state to IDLE;
  - the timeout counter to 0;
  - last_served to 1, so master 0 wins the first tie.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that master.
  - Both req: grant the master that is not last_served.
  - On a grant, at the same edge: latch that master's write/addr/wdata into write/waddr/wdata, set trans=1, set grantN=1, clear the counter, go to BUSY.
  - Latency: req seen at edge k -> trans=1 in cycle k+1.
- BUSY:
  - The bus outputs stay frozen. Later changes to the master's inputs, including a dropped req, are ignored.
  - readyout=1 at an edge:
    - trans=0;
    - pulse doneN;
    - if the latched write=0, capture rdata into rdataN;
    - set last_served=N;
    - go to RESP.
  - readyout=0 and counter==TIMEOUT-1:
    - trans=0;
    - pulse errN;
    - rdataN unchanged;
    - set last_served=N;
    - go to RESP.
  - Otherwise: counter+1.
  - If readyout=1 arrives on the timeout cycle, success wins.
- RESP:
  - done/err is high for exactly this cycle. grantN stays 1.
  - req inputs are not sampled; the master uses this edge to drop or refresh req.
  - Next edge: grantN=0, done/err=0, go to IDLE.
- Minimum transfer (readyout in the first BUSY cycle):
  - req sampled -> trans 1 cycle -> RESP 1 cycle -> IDLE.
  - Back-to-back transfers therefore have one IDLE cycle between them.
- Invariants:
  - grant0 and grant1 are never both 1.
  - trans=1 only in BUSY.
  - done/err is only ever asserted toward the granted master.
- waddr/wdata/write hold their last values when trans=0. The Peripheral ignores them.
- A req with no transfer behind it, or readyout while trans=0: ignored.

Decomposition:
- Shared package ahb_lite_pkg: state encodings (IDLE, BUSY, RESP), the default WIDTH=8, and the TIMEOUT default.
- One natural sub-module, ahb_lite_rr_pick: combinational 2-way round-robin picker.
  - Inputs: req0, req1, last_served.
  - Outputs: valid, winner.
- The FSM, timeout counter and bus registers stay in the top module.

Test Plan:
1. Reset, then req0 only, write0=1, addr0=8'h03, wdata0=8'h07; Peripheral readyout after 2 cycles -> trans=1 for 2 cycles with waddr=03, wdata=07, write=1; done0 pulses once; rdata0 stays 0; grant1 never 1.
2. req0 and req1 both raised in the same cycle, both reads (addr0=8'h01, addr1=8'h02), Peripheral returns 8'hA0+addr with readyout=1 immediately -> master 0 served first (rdata0=A1), then master 1 (rdata1=A2); exactly one IDLE cycle between the two trans pulses.
3. Both masters hold req continuously for 6 transfers -> grants alternate 0,1,0,1,0,1; no master starved.
4. Peripheral never asserts readyout, TIMEOUT=15 -> trans high for exactly 15 cycles, err1 pulses once, done1 stays 0, rdata1 unchanged; arbiter returns to IDLE and then serves the pending req0.
5. readyout=1 on exactly the 15th BUSY cycle -> done pulses, err stays 0.
6. Assert reset during BUSY -> trans, grant, done and err go to 0 asynchronously; after release, req1 pending alone is granted on the first sampled edge, with last_served back to 1.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared definitions for the two-master AHB-Lite arbiter: FSM state encoding
// and default geometry.
package ahb_lite_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int TIMEOUT_DEF = 15;
  localparam int TWIDTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ahb_lite_rr_pick.sv
// Combinational two-way round-robin picker: on a tie, the master that was not
// served last wins.
module ahb_lite_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_served,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last_served : req1;

endmodule

// File: rtl/ahb_lite_arbiter.sv
// Two-master, one-slave AHB-Lite-style arbiter: round-robin grant, single
// transfer per grant, timeout abort when the Peripheral stalls.
module ahb_lite_arbiter
  import ahb_lite_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TWIDTH  = TWIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             write0,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             grant0,
  output logic             done0,
  output logic             err0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             write1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             grant1,
  output logic             done1,
  output logic             err1,
  output logic [WIDTH-1:0] rdata1,
  output logic             write,
  output logic             trans,
  output logic [WIDTH-1:0] waddr,
  output logic [WIDTH-1:0] wdata,
  input  logic             readyout,
  input  logic [WIDTH-1:0] rdata
);

  state_e              state_q, state_d;
  logic [TWIDTH-1:0]   cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                grant0_q, grant0_d, grant1_q, grant1_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic                trans_q, trans_d, write_q, write_d;
  logic [WIDTH-1:0]    waddr_q, waddr_d, wdata_q, wdata_d;
  logic [WIDTH-1:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                pick_valid, pick_winner;

  ahb_lite_rr_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_served (last_q),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  // In BUSY/RESP the owner is simply whichever grant is set; grant1_q doubles as owner id.
  always_comb begin
    // NOTE: every signal takes a default before the case so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant0_d = grant0_q;
    grant1_d = grant1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    trans_d  = trans_q;
    write_d  = write_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant0_d = ~pick_winner;
          grant1_d = pick_winner;
          write_d  = pick_winner ? write1 : write0;
          waddr_d  = pick_winner ? addr1  : addr0;
          wdata_d  = pick_winner ? wdata1 : wdata0;
          trans_d  = 1'b1;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (readyout) begin
          trans_d = 1'b0;
          done0_d = ~grant1_q;
          done1_d = grant1_q;
          if (!write_q) begin
            if (grant1_q) rdata1_d = rdata;
            else          rdata0_d = rdata;
          end
          last_d  = grant1_q;
          state_d = ST_RESP;
        end else if (cnt_q == TWIDTH'(TIMEOUT - 1)) begin
          trans_d = 1'b0;
          err0_d  = ~grant1_q;
          err1_d  = grant1_q;
          last_d  = grant1_q;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + TWIDTH'(1);
        end
      end
      ST_RESP: begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      trans_q  <= 1'b0;
      write_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      trans_q  <= trans_d;
      write_q  <= write_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign grant0 = grant0_q;
  assign grant1 = grant1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign write  = write_q;
  assign trans  = trans_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;

endmodule
